acc_drain: RTL and testbench
============================

// Module: acc_drain
// PURPOSE
//  Output stage directly downstream of mac_array. On a capture pulse it snapshots all
//  ARRAY_SIZE accumulators in one cycle. It then streams them out one per beat over a
//  valid/ready handshake. Each beat is requantized: arithmetic right shift, then saturation
//  to OUT_DATA_WIDTH. The snapshot frees the MAC array to start its next tile immediately.
// PARAMETERS
//  ARRAY_SIZE              2   number of accumulator lanes; must be >= 1
//  ACCUMULATOR_DATA_WIDTH  16  width of each accumulator; signed two's complement
//  OUT_DATA_WIDTH          8   width of each output beat; signed; must be <= ACCUMULATOR_DATA_WIDTH
//  SHIFT                   0   arithmetic right shift applied before saturation; 0..ACC_W-1
// PORTS
//  clk           in   1                     clock, rising edge
//  rst           in   1                     synchronous, active-high reset
//  capture       in   1                     1-cycle pulse: snapshot accumulator[] and begin drain
//  accumulator   in   ACC_W x ARRAY_SIZE    unpacked array, straight from mac_array
//  out_data      out  OUT_W                 requantized lane value
//  out_index     out  $clog2(ARRAY_SIZE)+1  lane index of the current beat; ARRAY_SIZE=1 still gives 1 bit
//  out_valid     out  1                     beat is valid
//  out_ready     in   1                     consumer accepts the beat
//  busy          out  1                     drain in progress; high in DRAIN
//  done          out  1                     1-cycle pulse, cycle after the last beat is accepted
//  capture_err   out  1                     1-cycle pulse: capture arrived while busy and was dropped
// BEHAVIOUR
//  Reset: every output is 0, state = IDLE, idx = 0, snapshot bank cleared to 0.
//    A reset mid-drain abandons the drain; no done pulse is produced.
//  FSM, two states:
//    IDLE:  capture=1 -> latch snap[i] <= accumulator[i] for all i; idx <= 0; go to DRAIN.
//    DRAIN: out_valid=1. On accept (out_valid && out_ready):
//             idx == ARRAY_SIZE-1 -> go to IDLE; done=1 in the next cycle.
//             otherwise           -> idx <= idx+1.
//  Latency: capture at cycle N -> first out_valid at N+1. With out_ready held high, the drain
//    takes ARRAY_SIZE beats (cycles N+1..N+ARRAY_SIZE) and done fires at N+ARRAY_SIZE+1.
//  Handshake:
//    - out_data and out_index stay stable while out_valid && !out_ready.
//    - out_valid never drops without an accept.
//    - out_valid never depends combinationally on out_ready.
//  Lane order: ascending, lane 0 first.
//  Back-to-back drains: the same-cycle rule below is intentionally conservative. The earliest
//    next capture is the done cycle.
//  Simultaneous events:
//    - capture in DRAIN, including the final-accept cycle: dropped; capture_err=1 next cycle;
//      snapshot untouched.
//    - capture in the done cycle (state IDLE): accepted normally.
//  Arithmetic, per beat:
//    - t = snap[idx] >>> SHIFT (sign-extending).
//    - If t > 2^(OUT_W-1)-1, out_data = 2^(OUT_W-1)-1.
//    - Else if t < -2^(OUT_W-1), out_data = -2^(OUT_W-1).
//    - Else out_data = t[OUT_W-1:0].
//    - Rounding is truncation toward -inf; no round-half.
//  out_data is driven from registered snapshot state through the requant logic only.
//    No path from the accumulator inputs reaches the outputs.
//  Outside DRAIN: out_data and out_index read 0.
// STRUCTURE
//  utpu_pkg (shared package):
//    - typedef enum logic {IDLE, DRAIN} drain_state_t
//    - function sat_shift(), usable by later quantizing stages
//  Sub-module requant_sat #(IN_W, OUT_W, SHIFT): purely combinational shift+saturate, one instance.
//  Top-level sequential content: snapshot bank, idx counter, FSM, done/capture_err flops.
// TESTING (ARRAY_SIZE=4, ACC_W=16, OUT_W=8, SHIFT=2 unless noted)
//  1. acc={100,-4,1000,-1000}, capture, ready=1
//     -> beats (idx,data) = (0,25), (1,-1), (2,127), (3,-128) on 4 consecutive cycles;
//        done one cycle after the last beat.
//  2. Same acc, ready toggling 1,0,0,1,...
//     -> out_data/out_index held during stalls; exactly 4 accepts; done once.
//  3. Change accumulator[] every cycle after capture
//     -> streamed values equal the capture-cycle snapshot.
//  4. capture during beat 2
//     -> capture_err pulse next cycle; drain finishes with original data; no second drain.
//  5. rst asserted mid-drain at idx=1
//     -> next cycle all outputs 0, busy=0, no done; a fresh capture drains from idx 0.
//  6. SHIFT=0, OUT_W=16, acc={-32768,32767,0,1}
//     -> passes unchanged; capture issued in the done cycle is accepted back-to-back.

Source files
------------

// File: rtl/utpu_pkg.sv
// Shared types and arithmetic helpers for the accumulator output path.
package utpu_pkg;

  typedef enum logic {IDLE, DRAIN} drain_state_t;

  // Arithmetic right shift, then clamp to the signed range of out_w bits.
  // The result is sign-extended to 64 bits; callers keep the low out_w bits.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] value,
                                                   input int shift,
                                                   input int out_w);
    logic signed [63:0] t;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    t  = value >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (t > hi)      return hi;
    else if (t < lo) return lo;
    else             return t;
  endfunction

endpackage

// File: rtl/acc_drain_requant.sv
// Combinational requantizer: arithmetic right shift then signed saturation.
module requant_sat
  import utpu_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = 0
) (
  input  logic signed [IN_W-1:0]  in_data,
  output logic signed [OUT_W-1:0] out_data
);

  // The 64-bit cast sign-extends because in_data is signed.
  assign out_data = OUT_W'(sat_shift(64'(in_data), SHIFT, OUT_W));

endmodule

// File: rtl/acc_drain.sv
// Snapshots the MAC accumulators on capture, then streams requantized lanes
// over valid/ready, lowest lane first.
module acc_drain
  import utpu_pkg::*;
#(
  parameter int ARRAY_SIZE             = 2,
  parameter int ACCUMULATOR_DATA_WIDTH = 16,
  parameter int OUT_DATA_WIDTH         = 8,
  parameter int SHIFT                  = 0,
  localparam int IDX_W                 = $clog2(ARRAY_SIZE) + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              capture,
  input  logic [ACCUMULATOR_DATA_WIDTH-1:0] accumulator [ARRAY_SIZE],
  output logic [OUT_DATA_WIDTH-1:0]         out_data,
  output logic [IDX_W-1:0]                  out_index,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy,
  output logic                              done,
  output logic                              capture_err
);

  // Handshake: a beat transfers on a cycle where out_valid && out_ready.
  // out_valid comes straight from the state flop, so it never depends on
  // out_ready, and data/index only move on an accept.

  drain_state_t                             state;
  logic [IDX_W-1:0]                         idx;
  logic signed [ACCUMULATOR_DATA_WIDTH-1:0] snap [ARRAY_SIZE];
  logic signed [ACCUMULATOR_DATA_WIDTH-1:0] lane;
  logic signed [OUT_DATA_WIDTH-1:0]         lane_q;
  logic                                     last;

  always_comb begin
    lane = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      if (idx == IDX_W'(i)) lane = snap[i];
    end
  end

  requant_sat #(
    .IN_W  (ACCUMULATOR_DATA_WIDTH),
    .OUT_W (OUT_DATA_WIDTH),
    .SHIFT (SHIFT)
  ) u_requant (
    .in_data  (lane),
    .out_data (lane_q)
  );

  assign last      = (idx == IDX_W'(ARRAY_SIZE - 1));
  assign out_valid = (state == DRAIN);
  assign busy      = (state == DRAIN);
  assign out_data  = (state == DRAIN) ? lane_q : '0;
  assign out_index = (state == DRAIN) ? idx : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      done        <= 1'b0;
      capture_err <= 1'b0;
      for (int i = 0; i < ARRAY_SIZE; i++) snap[i] <= '0;
    end else begin
      done        <= 1'b0;
      capture_err <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            for (int i = 0; i < ARRAY_SIZE; i++) snap[i] <= accumulator[i];
            idx   <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // A capture while draining is dropped, even on the final accept.
          if (capture) capture_err <= 1'b1;
          if (out_ready) begin
            if (last) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_drain.sv
// Bench for acc_drain: a SHIFT=2/OUT_W=8 instance and a SHIFT=0/OUT_W=16 instance.
module tb_acc_drain;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        capture_a = 1'b0, ready_a = 1'b0;
  logic [15:0] acc_a [4];
  logic [7:0]  data_a;
  logic [2:0]  index_a;
  logic        valid_a, busy_a, done_a, err_a;

  logic        capture_b = 1'b0, ready_b = 1'b0;
  logic [15:0] acc_b [4];
  logic [15:0] data_b;
  logic [2:0]  index_b;
  logic        valid_b, busy_b, done_b, err_b;

  int tests_run    = 0;
  int tests_failed = 0;

  // Scoreboard entry: {lane index[2:0], expected data[15:0]}.
  logic [18:0] exp_q [$];

  acc_drain #(.ARRAY_SIZE(4), .ACCUMULATOR_DATA_WIDTH(16), .OUT_DATA_WIDTH(8), .SHIFT(2)) dut_a (
    .clk(clk), .rst(rst), .capture(capture_a), .accumulator(acc_a),
    .out_data(data_a), .out_index(index_a), .out_valid(valid_a), .out_ready(ready_a),
    .busy(busy_a), .done(done_a), .capture_err(err_a)
  );

  acc_drain #(.ARRAY_SIZE(4), .ACCUMULATOR_DATA_WIDTH(16), .OUT_DATA_WIDTH(16), .SHIFT(0)) dut_b (
    .clk(clk), .rst(rst), .capture(capture_b), .accumulator(acc_b),
    .out_data(data_b), .out_index(index_b), .out_valid(valid_b), .out_ready(ready_b),
    .busy(busy_b), .done(done_b), .capture_err(err_b)
  );

  function automatic logic [15:0] model_q(input int v, input int sh, input int ow);
    int t, mx, mn;
    t  = v >>> sh;
    mx = (1 << (ow - 1)) - 1;
    mn = -(1 << (ow - 1));
    if (t > mx)      t = mx;
    else if (t < mn) t = mn;
    return 16'(t);
  endfunction

  task automatic push_exp(input logic [15:0] v [4], input int sh, input int ow);
    for (int i = 0; i < 4; i++)
      exp_q.push_back({3'(i), model_q(int'($signed(v[i])), sh, ow)});
  endtask

  task automatic set_acc_a(input int a0, input int a1, input int a2, input int a3);
    acc_a[0] = 16'(a0); acc_a[1] = 16'(a1); acc_a[2] = 16'(a2); acc_a[3] = 16'(a3);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin acc_a[i] = '0; acc_b[i] = '0; end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({valid_a, busy_a, done_a, err_a} !== 4'b0 || data_a !== 8'd0 || index_a !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_a: got v/b/d/e=%b data=%h idx=%0d, expected all 0",
               {valid_a, busy_a, done_a, err_a}, data_a, index_a);
    end
    tests_run++;
    if ({valid_b, busy_b, done_b, err_b} !== 4'b0 || data_b !== 16'd0 || index_b !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_b: got v/b/d/e=%b data=%h idx=%0d, expected all 0",
               {valid_b, busy_b, done_b, err_b}, data_b, index_b);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Exact cycle timing with ready held high.
  task automatic test_basic();
    logic [18:0] e;
    set_acc_a(100, -4, 1000, -1000);
    ready_a = 1'b1; capture_a = 1'b1;
    push_exp(acc_a, 2, 8);
    @(negedge clk);
    capture_a = 1'b0;
    for (int b = 0; b < 4; b++) begin
      tests_run++;
      if (valid_a !== 1'b1 || done_a !== 1'b0) begin
        tests_failed++;
        $display("FAIL basic_valid beat %0d: got valid=%b done=%b, expected valid=1 done=0", b, valid_a, done_a);
      end
      e = exp_q.pop_front();
      tests_run++;
      if (index_a !== e[18:16] || data_a !== e[7:0]) begin
        tests_failed++;
        $display("FAIL basic_beat: got idx=%0d data=%h, expected idx=%0d data=%h", index_a, data_a, e[18:16], e[7:0]);
      end
      @(negedge clk);
    end
    tests_run++;
    if (done_a !== 1'b1 || valid_a !== 1'b0 || busy_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done: got done=%b valid=%b busy=%b, expected 1 0 0", done_a, valid_a, busy_a);
    end
    tests_run++;
    if (data_a !== 8'd0 || index_a !== 3'd0) begin
      tests_failed++;
      $display("FAIL basic_idle_zero: got data=%h idx=%0d, expected 0 0", data_a, index_a);
    end
    @(negedge clk);
    tests_run++;
    if (done_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done_pulse: got done=%b, expected 0", done_a);
    end
  endtask

  // Drain on dut_a with a given ready mode (0: 1,0,0,1 pattern, 1: random),
  // optionally scrambling the accumulator inputs every cycle.
  task automatic drain_a(input string name, input int mode, input bit scramble);
    logic [18:0] e;
    int accepts = 0, dones = 0;
    @(negedge clk);
    capture_a = 1'b0;
    for (int c = 0; c < 60 && dones == 0; c++) begin
      if (done_a) dones++;
      ready_a = (mode == 0) ? ((c % 4 == 0) || (c % 4 == 3)) : 1'($urandom_range(0, 1));
      if (valid_a) begin
        tests_run++;
        e = (exp_q.size() != 0) ? exp_q[0] : 19'h7ffff;
        if (index_a !== e[18:16] || data_a !== e[7:0]) begin
          tests_failed++;
          $display("FAIL %s_beat: got idx=%0d data=%h, expected idx=%0d data=%h", name, index_a, data_a, e[18:16], e[7:0]);
        end
        if (ready_a && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          accepts++;
        end
      end
      if (scramble) for (int i = 0; i < 4; i++) acc_a[i] = 16'($urandom_range(0, 65535));
      @(negedge clk);
    end
    ready_a = 1'b1;
    repeat (3) begin
      if (done_a) dones++;
      @(negedge clk);
    end
    tests_run++;
    if (accepts != 4 || dones != 1 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_count: got accepts=%0d dones=%0d left=%0d, expected 4 1 0", name, accepts, dones, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_stall();
    set_acc_a(100, -4, 1000, -1000);
    ready_a = 1'b0; capture_a = 1'b1;
    push_exp(acc_a, 2, 8);
    drain_a("stall", 0, 1'b0);
  endtask

  task automatic test_snapshot();
    for (int i = 0; i < 4; i++) acc_a[i] = 16'($urandom_range(0, 65535));
    ready_a = 1'b1; capture_a = 1'b1;
    push_exp(acc_a, 2, 8);
    drain_a("snapshot", 1, 1'b1);
  endtask

  task automatic test_capture_busy();
    logic [18:0] e;
    bit err_exp = 1'b0;
    int dones = 0, errs = 0, post = 0;
    set_acc_a(-7, 513, -515, 32767);
    ready_a = 1'b1; capture_a = 1'b1;
    push_exp(acc_a, 2, 8);
    @(negedge clk);
    capture_a = 1'b0;
    for (int c = 0; c < 40 && post < 4; c++) begin
      if (done_a) dones++;
      if (err_a) errs++;
      tests_run++;
      if (err_a !== err_exp) begin
        tests_failed++;
        $display("FAIL busy_err: got capture_err=%b, expected %b", err_a, err_exp);
      end
      err_exp = 1'b0;
      capture_a = 1'b0;
      if (dones > 0) begin
        post++;
        tests_run++;
        if (valid_a !== 1'b0) begin
          tests_failed++;
          $display("FAIL busy_no_second_drain: got valid=%b, expected 0", valid_a);
        end
      end
      if (valid_a) begin
        tests_run++;
        e = (exp_q.size() != 0) ? exp_q[0] : 19'h7ffff;
        if (index_a !== e[18:16] || data_a !== e[7:0]) begin
          tests_failed++;
          $display("FAIL busy_beat: got idx=%0d data=%h, expected idx=%0d data=%h", index_a, data_a, e[18:16], e[7:0]);
        end
        if (exp_q.size() == 2) begin
          capture_a = 1'b1;
          err_exp = 1'b1;
          set_acc_a(1, 2, 3, 4);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    capture_a = 1'b0;
    tests_run++;
    if (dones != 1 || errs != 1 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL busy_count: got dones=%0d errs=%0d left=%0d, expected 1 1 0", dones, errs, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    set_acc_a(400, -400, 40, -40);
    ready_a = 1'b1; capture_a = 1'b1;
    @(negedge clk);
    capture_a = 1'b0;
    @(negedge clk);
    tests_run++;
    if (valid_a !== 1'b1 || index_a !== 3'd1) begin
      tests_failed++;
      $display("FAIL rstmid_at_idx1: got valid=%b idx=%0d, expected 1 1", valid_a, index_a);
    end
    rst = 1'b1; ready_a = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({valid_a, busy_a, done_a, err_a} !== 4'b0 || data_a !== 8'd0 || index_a !== 3'd0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: got v/b/d/e=%b data=%h idx=%0d, expected all 0",
               {valid_a, busy_a, done_a, err_a}, data_a, index_a);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if (done_a !== 1'b0 || valid_a !== 1'b0) begin
        tests_failed++;
        $display("FAIL rstmid_quiet: got done=%b valid=%b, expected 0 0", done_a, valid_a);
      end
    end
    set_acc_a(-9, 9, -129, 600);
    ready_a = 1'b1; capture_a = 1'b1;
    push_exp(acc_a, 2, 8);
    drain_a("rstmid_fresh", 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [18:0] e;
    int dones = 0, beats = 0;
    bit expect_first = 1'b0;
    acc_b[0] = 16'h8000; acc_b[1] = 16'h7fff; acc_b[2] = 16'h0000; acc_b[3] = 16'h0001;
    ready_b = 1'b1; capture_b = 1'b1;
    push_exp(acc_b, 0, 16);
    @(negedge clk);
    capture_b = 1'b0;
    for (int c = 0; c < 30 && dones < 2; c++) begin
      capture_b = 1'b0;
      if (expect_first) begin
        tests_run++;
        if (valid_b !== 1'b1 || index_b !== 3'd0) begin
          tests_failed++;
          $display("FAIL b2b_restart: got valid=%b idx=%0d, expected 1 0", valid_b, index_b);
        end
        expect_first = 1'b0;
      end
      if (valid_b) begin
        tests_run++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 19'h7ffff;
        beats++;
        if (index_b !== e[18:16] || data_b !== e[15:0]) begin
          tests_failed++;
          $display("FAIL b2b_beat: got idx=%0d data=%h, expected idx=%0d data=%h", index_b, data_b, e[18:16], e[15:0]);
        end
      end
      if (done_b) begin
        dones++;
        if (dones == 1) begin
          acc_b[0] = 16'(5); acc_b[1] = 16'(-5); acc_b[2] = 16'(1234); acc_b[3] = 16'(-1234);
          capture_b = 1'b1;
          push_exp(acc_b, 0, 16);
          expect_first = 1'b1;
        end
      end
      @(negedge clk);
    end
    capture_b = 1'b0;
    tests_run++;
    if (beats != 8 || dones != 2 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_count: got beats=%0d dones=%0d left=%0d, expected 8 2 0", beats, dones, exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_snapshot();
    test_capture_busy();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
